// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back data cache (8 blocks x 4 bytes)
// with its miss-handling FSM between the CPU load/store path and block memory.
// Optional build macro DCACHE_STATS_EN adds saturating hit/miss counters.
module dcache_controller #(
    parameter int INDEX_BITS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  address,
    input  logic [7:0]  writedata,
    output logic [7:0]  readdata,
    output logic        busywait,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    localparam int TAG_BITS   = 6 - INDEX_BITS;
    localparam int NUM_BLOCKS = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM_WRITE,
        ST_MEM_READ,
        ST_UPDATE
    } cacheState;

    cacheState stateReg, stateNext;

    logic [31:0]           dataArray [NUM_BLOCKS];
    logic [TAG_BITS-1:0]   tagArray  [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] validBits;
    logic [NUM_BLOCKS-1:0] dirtyBits;

    logic [TAG_BITS-1:0]   reqTag;
    logic [INDEX_BITS-1:0] reqIndex;
    logic [1:0]            reqOffset;
    logic [TAG_BITS-1:0]   missTag;
    logic [INDEX_BITS-1:0] missIndex;

    logic request;
    logic hit;
    logic readHit;
    logic writeHit;
    logic missStart;

    assign reqTag    = address[7:INDEX_BITS+2];
    assign reqIndex  = address[INDEX_BITS+1:2];
    assign reqOffset = address[1:0];

    // Lookup: a request hits when the indexed block is valid and its tag matches.
    always_comb begin
        request   = read | write;
        hit       = validBits[reqIndex] && (tagArray[reqIndex] == reqTag);
        readHit   = (stateReg == ST_IDLE) && hit && read && !write;
        writeHit  = (stateReg == ST_IDLE) && hit && write;
        missStart = (stateReg == ST_IDLE) && request && !hit;
    end

    // CPU-side outputs: stall unless the access is served from IDLE this cycle.
    always_comb begin
        busywait = !reset && request && !((stateReg == ST_IDLE) && hit);
        readdata = 8'h00;
        if (readHit) begin
            readdata = dataArray[reqIndex][{reqOffset, 3'b000} +: 8];
        end
    end

    // State register plus the block address captured when a miss starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg  <= ST_IDLE;
            missTag   <= '0;
            missIndex <= '0;
        end else begin
            stateReg <= stateNext;
            if (missStart) begin
                missTag   <= reqTag;
                missIndex <= reqIndex;
            end
        end
    end

    // Next-state and memory-side outputs for the miss sequence.
    always_comb begin
        stateNext     = stateReg;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = {missTag, missIndex};
        mem_writedata = dataArray[missIndex];
        case (stateReg)
            ST_IDLE: begin
                if (missStart) begin
                    if (validBits[reqIndex] && dirtyBits[reqIndex]) begin
                        stateNext = ST_MEM_WRITE;
                    end else begin
                        stateNext = ST_MEM_READ;
                    end
                end
            end
            ST_MEM_WRITE: begin
                mem_write   = 1'b1;
                mem_address = {tagArray[missIndex], missIndex};
                if (!mem_busywait) begin
                    stateNext = ST_MEM_READ;
                end
            end
            ST_MEM_READ: begin
                mem_read = 1'b1;
                if (!mem_busywait) begin
                    stateNext = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                stateNext = ST_IDLE;
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    // Valid/dirty bookkeeping: a fill makes the block clean, a store hit dirties it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validBits <= '0;
            dirtyBits <= '0;
        end else if (stateReg == ST_UPDATE) begin
            validBits[missIndex] <= 1'b1;
            dirtyBits[missIndex] <= 1'b0;
        end else if (writeHit) begin
            dirtyBits[reqIndex] <= 1'b1;
        end
    end

    // Data and tag storage: block fill on UPDATE, single-byte merge on a store hit.
    always_ff @(posedge clk) begin
        if (stateReg == ST_UPDATE) begin
            dataArray[missIndex] <= mem_readdata;
            tagArray[missIndex]  <= missTag;
        end else if (writeHit) begin
            dataArray[reqIndex][{reqOffset, 3'b000} +: 8] <= writedata;
        end
    end

`ifdef DCACHE_STATS_EN
    logic        missSeen;
    logic [15:0] hitCount;
    logic [15:0] missCount;

    // Saturating counters; the hit that completes a miss is not counted as a hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            missSeen  <= 1'b0;
            hitCount  <= 16'h0000;
            missCount <= 16'h0000;
        end else if (stateReg == ST_IDLE) begin
            if (request && !hit) begin
                missSeen <= 1'b1;
                if (missCount != 16'hFFFF) begin
                    missCount <= missCount + 16'd1;
                end
            end else begin
                missSeen <= 1'b0;
                if (request && hit && !missSeen && (hitCount != 16'hFFFF)) begin
                    hitCount <= hitCount + 16'd1;
                end
            end
        end
    end

    assign hit_count  = hitCount;
    assign miss_count = missCount;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed and random accesses against a flat byte-array
// view of memory plus a resident-block table, with a latency-programmable memory.
module tb_dcache_controller;

    logic        clk;
    logic        reset;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int tests = 0;
    int fails = 0;
    int tmem  = 5;
    int memCnt;

    logic [31:0] memModel [64];
    bit          written  [64];

    logic [7:0] refMem   [256];
    logic [2:0] refTag   [8];
    bit         refValid [8];
    bit         refDirty [8];

    dcache_controller dut (
        .clk           (clk),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power-on content of each memory block; block 9 is pinned for the directed steps.
    function automatic logic [31:0] initWord(input logic [5:0] a);
        logic [31:0] m;
        if (a == 6'h09) return 32'hDDCCBBAA;
        m = 32'h9E3779B9 * (32'(a) + 32'd1);
        return m ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] memView(input logic [5:0] a);
        if (written[a]) return memModel[a];
        return initWord(a);
    endfunction

    // Memory device: busy for tmem-1 cycles of a request, ready in the tmem-th.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            memCnt <= 0;
        end else if (mem_read || mem_write) begin
            if (memCnt >= tmem - 1) begin
                memCnt <= 0;
                if (mem_write) begin
                    memModel[mem_address] <= mem_writedata;
                    written[mem_address]  <= 1'b1;
                end
            end else begin
                memCnt <= memCnt + 1;
            end
        end else begin
            memCnt <= 0;
        end
    end

    assign mem_busywait = (mem_read || mem_write) && (memCnt < tmem - 1);

    // Memory read port returns the current block content.
    always_comb begin
        if (written[mem_address]) mem_readdata = memModel[mem_address];
        else mem_readdata = initWord(mem_address);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Empty cache; CPU view of every byte falls back to what memory holds.
    task automatic resetModel();
        logic [31:0] w;
        for (int i = 0; i < 8; i++) begin
            refValid[i] = 1'b0;
            refDirty[i] = 1'b0;
            refTag[i]   = 3'd0;
        end
        for (int a = 0; a < 256; a++) begin
            w = memView(6'(a >> 2));
            refMem[a] = w[8*(a%4) +: 8];
        end
    endtask

    // One CPU access held until the stall clears; checks against the reference view.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] addr,
                                 input logic [7:0] wdata, output int busyCycles,
                                 output logic [7:0] rdata, output logic sawWb,
                                 output logic [5:0] wbAddr, output logic [31:0] wbData,
                                 output logic sawRd, output logic [5:0] rdAddr);
        logic [2:0]  idx;
        logic [2:0]  tg;
        logic        expHit;
        logic        expWb;
        logic [7:0]  vb;
        logic [31:0] expWbData;
        logic [7:0]  expRead;
        idx       = addr[4:2];
        tg        = addr[7:5];
        expHit    = refValid[idx] && (refTag[idx] == tg);
        expWb     = !expHit && refValid[idx] && refDirty[idx];
        vb        = {refTag[idx], idx, 2'b00};
        expWbData = {refMem[vb | 8'd3], refMem[vb | 8'd2], refMem[vb | 8'd1], refMem[vb]};
        expRead   = (rd && !wr) ? refMem[addr] : 8'h00;
        sawWb = 1'b0; sawRd = 1'b0; wbAddr = '0; wbData = '0; rdAddr = '0;

        @(negedge clk); #1;
        read = rd; write = wr; address = addr; writedata = wdata;
        #1;
        checkOutput("hit_predict", 32'(busywait), 32'(!expHit));
        busyCycles = 0;
        while (busywait && busyCycles < 100) begin
            checkOutput("mem_exclusive", 32'(mem_read && mem_write), 32'd0);
            if (mem_write && !sawWb) begin
                sawWb = 1'b1; wbAddr = mem_address; wbData = mem_writedata;
            end
            if (mem_read && !sawRd) begin
                sawRd = 1'b1; rdAddr = mem_address;
            end
            busyCycles++;
            @(negedge clk); #1;
        end
        if (busyCycles >= 100) checkOutput("stall_timeout", 32'(busyCycles), 32'd0);
        rdata = readdata;
        checkOutput("readdata", 32'(rdata), 32'(expRead));
        checkOutput("wb_seen", 32'(sawWb), 32'(expWb));
        if (expWb) begin
            checkOutput("wb_addr", 32'(wbAddr), 32'({refTag[idx], idx}));
            checkOutput("wb_data", wbData, expWbData);
        end
        checkOutput("fill_seen", 32'(sawRd), 32'(!expHit));
        if (!expHit) checkOutput("fill_addr", 32'(rdAddr), 32'({tg, idx}));

        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
        refValid[idx] = 1'b1;
        refTag[idx]   = tg;
        if (!expHit) refDirty[idx] = 1'b0;
        if (wr) begin
            refMem[addr]  = wdata;
            refDirty[idx] = 1'b1;
        end
    endtask

    // Safety net so the run always ends.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    // Directed steps followed by a random sweep.
    initial begin
        int          bc;
        logic [7:0]  rv;
        logic        sWb, sRd;
        logic [5:0]  wA, rA;
        logic [31:0] wD;
        logic [31:0] r;
        logic [1:0]  op;

        reset = 1'b1; read = 1'b0; write = 1'b0; address = 8'h00; writedata = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_busywait", 32'(busywait), 32'd0);
        checkOutput("reset_mem_read", 32'(mem_read), 32'd0);
        checkOutput("reset_mem_write", 32'(mem_write), 32'd0);
        checkOutput("reset_readdata", 32'(readdata), 32'd0);
        reset = 1'b0;
        resetModel();

        // Cold read miss on 0x24 with a 5-cycle memory.
        tmem = 5;
        applyStimulus(1'b1, 1'b0, 8'h24, 8'h00, bc, rv, sWb, wA, wD, sRd, rA);
        checkOutput("cold_miss_cycles", 32'(bc), 32'd7);
        checkOutput("cold_miss_addr", 32'(rA), 32'h09);
        checkOutput("cold_miss_data", 32'(rv), 32'hAA);

        // Same block, other byte: zero-stall hit.
        applyStimulus(1'b1, 1'b0, 8'h26, 8'h00, bc, rv, sWb, wA, wD, sRd, rA);
        checkOutput("hit_cycles", 32'(bc), 32'd0);
        checkOutput("hit_data", 32'(rv), 32'hCC);

        // Store hit then conflicting read forces a write-back.
        applyStimulus(1'b0, 1'b1, 8'h24, 8'h5A, bc, rv, sWb, wA, wD, sRd, rA);
        checkOutput("store_hit_cycles", 32'(bc), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h64, 8'h00, bc, rv, sWb, wA, wD, sRd, rA);
        checkOutput("evict_wb_addr", 32'(wA), 32'h09);
        checkOutput("evict_wb_data", wD, 32'hDDCCBB5A);
        checkOutput("evict_fill_addr", 32'(rA), 32'h19);

        // Reset pulsed while a fill is outstanding.
        @(negedge clk); #1;
        read = 1'b1; write = 1'b0; address = 8'h24;
        @(negedge clk); #1;
        checkOutput("midfill_mem_read", 32'(mem_read), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rst_mem_read", 32'(mem_read), 32'd0);
        checkOutput("rst_busywait", 32'(busywait), 32'd0);
        checkOutput("rst_mem_write", 32'(mem_write), 32'd0);
        read = 1'b0;
        #1;
        reset = 1'b0;
        resetModel();
        applyStimulus(1'b1, 1'b0, 8'h24, 8'h00, bc, rv, sWb, wA, wD, sRd, rA);
        checkOutput("post_rst_miss_cycles", 32'(bc), 32'd7);

        // READ and WRITE together act as a store.
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, bc, rv, sWb, wA, wD, sRd, rA);
        applyStimulus(1'b1, 1'b1, 8'h00, 8'h11, bc, rv, sWb, wA, wD, sRd, rA);
        checkOutput("both_hit_cycles", 32'(bc), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, bc, rv, sWb, wA, wD, sRd, rA);
        checkOutput("both_readback", 32'(rv), 32'h11);

`ifdef DCACHE_STATS_EN
        // Counters: one miss plus three hits, then saturation.
        @(negedge clk); #1; reset = 1'b1; #2; reset = 1'b0;
        resetModel();
        applyStimulus(1'b1, 1'b0, 8'h80, 8'h00, bc, rv, sWb, wA, wD, sRd, rA);
        applyStimulus(1'b1, 1'b0, 8'h80, 8'h00, bc, rv, sWb, wA, wD, sRd, rA);
        applyStimulus(1'b1, 1'b0, 8'h81, 8'h00, bc, rv, sWb, wA, wD, sRd, rA);
        applyStimulus(1'b1, 1'b0, 8'h82, 8'h00, bc, rv, sWb, wA, wD, sRd, rA);
        checkOutput("stats_miss", 32'(miss_count), 32'd1);
        checkOutput("stats_hit", 32'(hit_count), 32'd3);
        force dut.hitCount = 16'hFFFF;
        @(negedge clk);
        release dut.hitCount;
        applyStimulus(1'b1, 1'b0, 8'h83, 8'h00, bc, rv, sWb, wA, wD, sRd, rA);
        checkOutput("stats_hit_sat", 32'(hit_count), 32'hFFFF);
        checkOutput("stats_miss_hold", 32'(miss_count), 32'd1);
`endif

        // Random sweep over the whole address space with varying memory latency.
        for (int n = 0; n < 300; n++) begin
            r    = $urandom();
            tmem = int'($urandom_range(5, 2));
            op   = r[11:10];
            applyStimulus(op != 2'd2, op >= 2'd2, r[7:0], r[23:16],
                          bc, rv, sWb, wA, wD, sRd, rA);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
